ram_cb_param: RTL and testbench
===============================

RAM_CB_PARAM -- requirements
Module: ram_cb_param

Interface
REQ-001 Parameter DW, default 18: sample width in bits.
REQ-002 Parameter LANES, default 8: parallel read lanes; power of two, 2..16.
REQ-003 Parameter AW, default 11: row address width; total depth N = LANES*2^AW samples (default 16384).
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 xin  input  DW  sample to write.
REQ-007 enxk  input  1  one-cycle write strobe; xin written when high.
REQ-008 rd_en  input  1  read request; addrin sampled when high.
REQ-009 addrin  input  AW  read row, i.e. delay group.
REQ-010 rdout  output  LANES*DW  lane 0 in the MSBs, lane LANES-1 in the LSBs.
REQ-011 rd_valid  output  1  rdout valid this cycle.
REQ-012 fill_cnt  output  AW+log2(LANES)+1  samples written since reset, saturating at N.
REQ-013 full  output  1  high when fill_cnt == N.

Function
REQ-014 Circular buffer of N samples; write pointer wp, 0..N-1, points to the next write slot.
REQ-015 enxk=1: mem[wp] <= xin; wp <= (wp+1) mod N; wraps from N-1 to 0.
REQ-016 enxk=1: fill_cnt increments by 1 if below N, otherwise holds.
REQ-017 Newest sample index h = (wp-1) mod N.
REQ-018 Read at addrin=a: lane k returns sample at delay d = a*LANES + k, i.e. mem[(h-d) mod N], k=0..LANES-1.
REQ-019 Storage: LANES single-port-read banks; sample index s lives in bank s mod LANES, row s/LANES; one read per bank per request; output lanes rotated by h mod LANES.
REQ-020 Latency: rd_en at cycle t gives rd_valid=1 with data at cycle t+2; one request per cycle accepted, fully pipelined.
REQ-021 rd_valid is low in every cycle without a matching request; rdout holds its last value when rd_valid=0.
REQ-022 Simultaneous enxk and rd_en: the read uses h before this write; the new sample is visible to requests from the next cycle.
REQ-023 Write-after-read hazard: a write landing in a bank row that an in-flight read targets does not alter that read's data.
REQ-024 addrin is unsigned with no range check; a = 2^AW-1 reads delays N-LANES..N-1.

Reset
REQ-025 reset=0 at a rising edge: wp=0, fill_cnt=0, full=0, rd_valid=0, rdout=0.
REQ-026 Reset in the middle of a read discards in-flight requests; no rd_valid is produced for them.
REQ-027 Memory contents are not cleared by reset.
REQ-028 enxk and rd_en are ignored while reset=0.

Configuration
REQ-029 Macro RAM_CB_ZEROFILL_EN.
REQ-030 Defined: any lane with delay d >= fill_cnt outputs 0 instead of memory contents; output is never undefined after reset.
REQ-031 Not defined: lanes return raw memory contents regardless of fill_cnt; no compare logic is present.

Verification (default parameters)
REQ-032 Reset, write xin=1..16 (one enxk each), rd_en with a=0 -> two cycles later rd_valid=1 and lanes 0..7 = 16,15,...,9; a=1 -> 8,7,...,1; fill_cnt=16.
REQ-033 Write 16390 samples with value = index+1 -> full=1 and fill_cnt=16384; a=0 gives 16390..16383; a=2047 gives lanes 0..7 = 14..7, across the wrap.
REQ-034 With RAM_CB_ZEROFILL_EN: after 5 writes (1..5), a=0 -> lanes 0..4 = 5..1, lanes 5..7 = 0. Without the macro, lanes 0..4 match and lanes 5..7 are not checked.
REQ-035 Same cycle: enxk with xin=100 and rd_en with a=0, after samples 1..8 -> lanes = 8..1. A read issued the next cycle -> 100,8,...,2.
REQ-036 rd_en held high for 4 cycles with a=0,1,2,3 -> rd_valid high for exactly 4 consecutive cycles starting 2 cycles later, with matching data; reset pulsed one cycle after the last rd_en -> no further rd_valid, fill_cnt=0, rdout=0.

Source files
------------

// File: rtl/ram_cb_param_if.sv
// Bus bundle for ram_cb_param: write strobe/sample, read request and read/fill status.
interface ram_cb_param_if #(
  parameter int DW    = 18,
  parameter int LANES = 8,
  parameter int AW    = 11
);
  localparam int FW = AW + $clog2(LANES) + 1;

  logic [DW-1:0]       xin;
  logic                enxk;
  logic                rd_en;
  logic [AW-1:0]       addrin;
  logic [LANES*DW-1:0] rdout;
  logic                rd_valid;
  logic [FW-1:0]       fill_cnt;
  logic                full;

  modport master (
    output xin, enxk, rd_en, addrin,
    input  rdout, rd_valid, fill_cnt, full
  );

  modport slave (
    input  xin, enxk, rd_en, addrin,
    output rdout, rd_valid, fill_cnt, full
  );
endinterface

// File: rtl/ram_cb_param.sv
// Banked circular delay-line buffer returning LANES consecutive delays per read, 2-cycle latency.
// Optional macro RAM_CB_ZEROFILL_EN forces lanes whose delay is not yet written to zero.
module ram_cb_param #(
  parameter int DW    = 18,
  parameter int LANES = 8,
  parameter int AW    = 11
) (
  input logic           clock,
  input logic           reset,
  ram_cb_param_if.slave bus
);
  localparam int LB   = $clog2(LANES);
  localparam int NB   = AW + LB;
  localparam int FW   = NB + 1;
  localparam int ROWS = 1 << AW;
  localparam logic [FW-1:0] N_C = FW'(LANES) << AW;

  logic [NB-1:0]       wp_q, wp_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic                full_q, full_d;
  logic                s1_valid_q, s1_valid_d;
  logic [LB-1:0]       s1_rot_q, s1_rot_d;
  logic                rd_valid_q, rd_valid_d;
  logic [LANES*DW-1:0] rdout_q, rdout_d;
`ifdef RAM_CB_ZEROFILL_EN
  logic [AW-1:0]       s1_addr_q, s1_addr_d;
  logic [FW-1:0]       s1_fill_q, s1_fill_d;
`endif

  logic [NB-1:0]       head_s;
  logic [LANES*DW-1:0] bank_rd_s;
  logic [LB-1:0]       sel_s;
  logic [DW-1:0]       lane_s;

  assign head_s = wp_q - NB'(1);

  // Bank b holds the lane whose sample index is congruent to b; it needs one fewer row
  // than the head row when b lies above the head's bank position.
  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [DW-1:0] mem_q [ROWS];
    logic [DW-1:0] dout_q;
    logic [AW-1:0] row_s;

    assign row_s = head_s[NB-1:LB] - bus.addrin - AW'(LB'(b) > head_s[LB-1:0]);

    // Bank write port and registered read (old data on same-address write).
    always_ff @(posedge clock) begin
      if (reset && bus.enxk && (wp_q[LB-1:0] == LB'(b))) begin
        mem_q[wp_q[NB-1:LB]] <= bus.xin;
      end
      dout_q <= mem_q[row_s];
    end

    assign bank_rd_s[b*DW +: DW] = dout_q;
  end

  // Next-state: write pointer, fill level, read pipeline and lane rotation.
  always_comb begin
    wp_d       = wp_q;
    fill_d     = fill_q;
    full_d     = full_q;
    s1_valid_d = bus.rd_en;
    s1_rot_d   = s1_rot_q;
    rd_valid_d = s1_valid_q;
    rdout_d    = rdout_q;
    sel_s      = '0;
    lane_s     = '0;
`ifdef RAM_CB_ZEROFILL_EN
    s1_addr_d  = s1_addr_q;
    s1_fill_d  = s1_fill_q;
`endif

    if (bus.enxk) begin
      wp_d = wp_q + NB'(1);
      if (fill_q != N_C) begin
        fill_d = fill_q + FW'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      wp_d   = wp_q;
      fill_d = fill_q;
    end
    full_d = (fill_d == N_C);

    if (bus.rd_en) begin
      s1_rot_d  = head_s[LB-1:0];
`ifdef RAM_CB_ZEROFILL_EN
      s1_addr_d = bus.addrin;
      s1_fill_d = fill_q;
`endif
    end else begin
      s1_rot_d  = s1_rot_q;
    end

    if (s1_valid_q) begin
      for (int k = 0; k < LANES; k++) begin
        sel_s  = s1_rot_q - LB'(k);
        lane_s = bank_rd_s[int'(sel_s)*DW +: DW];
`ifdef RAM_CB_ZEROFILL_EN
        if ({1'b0, s1_addr_q, LB'(k)} >= s1_fill_q) begin
          lane_s = '0;
        end else begin
          lane_s = bank_rd_s[int'(sel_s)*DW +: DW];
        end
`endif
        rdout_d[(LANES-1-k)*DW +: DW] = lane_s;
      end
    end else begin
      rdout_d = rdout_q;
    end
  end

  // State registers with synchronous active-low reset; memory is left untouched.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_q       <= '0;
      fill_q     <= '0;
      full_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_rot_q   <= '0;
      rd_valid_q <= 1'b0;
      rdout_q    <= '0;
`ifdef RAM_CB_ZEROFILL_EN
      s1_addr_q  <= '0;
      s1_fill_q  <= '0;
`endif
    end else begin
      wp_q       <= wp_d;
      fill_q     <= fill_d;
      full_q     <= full_d;
      s1_valid_q <= s1_valid_d;
      s1_rot_q   <= s1_rot_d;
      rd_valid_q <= rd_valid_d;
      rdout_q    <= rdout_d;
`ifdef RAM_CB_ZEROFILL_EN
      s1_addr_q  <= s1_addr_d;
      s1_fill_q  <= s1_fill_d;
`endif
    end
  end

  assign bus.rdout    = rdout_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.fill_cnt = fill_q;
  assign bus.full     = full_q;
endmodule

// File: tb/tb_ram_cb_param.sv
// Scoreboard bench for ram_cb_param: directed scenarios plus random traffic against an array model.
module tb_ram_cb_param;
  localparam int DW    = 18;
  localparam int LANES = 8;
  localparam int AW    = 11;
  localparam int N     = LANES << AW;
  localparam int FW    = AW + $clog2(LANES) + 1;

  typedef struct packed {
    logic [31:0]         due;
    logic [LANES*DW-1:0] v;
    logic [LANES-1:0]    chk;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  ram_cb_param_if #(.DW(DW), .LANES(LANES), .AW(AW)) bus ();

  ram_cb_param #(.DW(DW), .LANES(LANES), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int   model_mem [N];
  int   model_wp   = 0;
  int   model_fill = 0;
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;
  bit   hold_known = 1'b0;
  logic [LANES*DW-1:0] exp_hold = '0;
  bit   dir_on = 1'b0;
  logic [LANES*DW-1:0] dir_v;
  logic [LANES-1:0]    dir_chk;

  // Lane k expected at delay a*LANES+k counted back from the newest sample.
  function automatic exp_t model_read(input int a);
    exp_t e;
    e = '0;
    for (int k = 0; k < LANES; k++) begin
      int d;
      int idx;
      d   = a * LANES + k;
      idx = ((model_wp - 1 - d) % N + N) % N;
      if (d < model_fill) begin
        e.v[(LANES-1-k)*DW +: DW] = DW'(model_mem[idx]);
        e.chk[k] = 1'b1;
      end else begin
`ifdef RAM_CB_ZEROFILL_EN
        e.chk[k] = 1'b1;
`else
        e.chk[k] = 1'b0;
`endif
      end
    end
    return e;
  endfunction

  function automatic logic [LANES*DW-1:0] desc(input int top);
    logic [LANES*DW-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) v[(LANES-1-k)*DW +: DW] = DW'(top - k);
    return v;
  endfunction

  function automatic logic [LANES*DW-1:0] lane_mask(input logic [LANES-1:0] chk);
    logic [LANES*DW-1:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++) if (chk[k]) m[(LANES-1-k)*DW +: DW] = '1;
    return m;
  endfunction

  task automatic step(input bit we, input int x, input bit re, input int a, input bit rst);
    exp_t e;
    bus.enxk   = we;
    bus.xin    = DW'(x);
    bus.rd_en  = re;
    bus.addrin = AW'(a);
    reset      = rst ? 1'b0 : 1'b1;
    if (rst) begin
      while (sb.size() > 0 && int'(sb[$].due) > cyc) void'(sb.pop_back());
    end else if (re) begin
      if (dir_on) begin
        e.v   = dir_v;
        e.chk = dir_chk;
      end else begin
        e = model_read(a);
      end
      e.due = 32'(cyc + 2);
      sb.push_back(e);
    end
    @(posedge clock);
    if (rst) begin
      model_wp   = 0;
      model_fill = 0;
      hold_known = 1'b1;
      exp_hold   = '0;
    end else if (we) begin
      model_mem[model_wp] = x & ((1 << DW) - 1);
      model_wp = (model_wp + 1) % N;
      if (model_fill < N) model_fill++;
    end
    #1;
  endtask

  task automatic step_dir(input bit we, input int x, input int a,
                          input logic [LANES*DW-1:0] v, input logic [LANES-1:0] chk);
    dir_on  = 1'b1;
    dir_v   = v;
    dir_chk = chk;
    step(we, x, 1'b1, a, 1'b0);
    dir_on  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  // Monitor: status every cycle, read responses popped from the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    logic [LANES*DW-1:0] m;
    if (mon_on) begin
      n_chk++;
      if (bus.fill_cnt !== FW'(model_fill)) begin
        n_fail++;
        $display("FAIL fill_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.fill_cnt, model_fill);
      end
      n_chk++;
      if (bus.full !== (model_fill == N)) begin
        n_fail++;
        $display("FAIL full cyc=%0d got=%b exp=%b", cyc, bus.full, (model_fill == N));
      end
      n_chk++;
      if (bus.rd_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rd_valid_spurious cyc=%0d got=1 exp=0", cyc);
        end else begin
          e = sb.pop_front();
          if (int'(e.due) != cyc) begin
            n_fail++;
            $display("FAIL rd_latency got_cyc=%0d exp_cyc=%0d", cyc, e.due);
          end
          n_chk++;
          m = lane_mask(e.chk);
          if ((bus.rdout & m) !== (e.v & m)) begin
            n_fail++;
            $display("FAIL rd_data cyc=%0d got=%h exp=%h mask=%h", cyc, bus.rdout, e.v, m);
          end
          hold_known = &e.chk;
          exp_hold   = e.v;
        end
      end else if (bus.rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_valid_x cyc=%0d got=%b exp=0/1", cyc, bus.rd_valid);
      end else if (sb.size() > 0 && int'(sb[0].due) <= cyc) begin
        n_fail++;
        $display("FAIL rd_valid_missing cyc=%0d got=0 exp=1 (due %0d)", cyc, sb[0].due);
        void'(sb.pop_front());
      end else if (hold_known) begin
        n_chk++;
        if (bus.rdout !== exp_hold) begin
          n_fail++;
          $display("FAIL rdout_hold cyc=%0d got=%h exp=%h", cyc, bus.rdout, exp_hold);
        end
      end
    end
  end

  initial begin
    logic [LANES*DW-1:0] v;
    logic [LANES-1:0]    c;
    bus.enxk = 1'b0; bus.xin = '0; bus.rd_en = 1'b0; bus.addrin = '0;

    do_reset();
    mon_on = 1'b1;
    step(1'b1, 77, 1'b1, 0, 1'b1);
    step(1'b1, 78, 1'b1, 1, 1'b1);
    n_chk++;
    if (bus.rdout !== '0 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%h/%b exp=0/0", bus.rdout, bus.rd_valid);
    end

    // Basic 16-sample fill, two rows.
    for (int i = 1; i <= 16; i++) step(1'b1, i, 1'b0, 0, 1'b0);
    step_dir(1'b0, 0, 0, desc(16), '1);
    step_dir(1'b0, 0, 1, desc(8), '1);
    idle(3);

    // Same-cycle write and read, then read seeing the new sample.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 0, 1'b0);
    step_dir(1'b1, 100, 0, desc(8), '1);
    v = desc(9);
    v[(LANES-1)*DW +: DW] = DW'(100);
    step_dir(1'b0, 0, 0, v, '1);
    idle(3);

    // Partially filled buffer.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, i, 1'b0, 0, 1'b0);
    v = desc(5);
    for (int k = 5; k < LANES; k++) v[(LANES-1-k)*DW +: DW] = '0;
`ifdef RAM_CB_ZEROFILL_EN
    c = '1;
`else
    c = 8'h1F;
`endif
    step_dir(1'b0, 0, 0, v, c);
    idle(3);

    // Back-to-back reads, then reset.
    do_reset();
    for (int i = 1; i <= 32; i++) step(1'b1, i, 1'b0, 0, 1'b0);
    for (int a = 0; a < 4; a++) step_dir(1'b0, 0, a, desc(32 - 8 * a), '1);
    idle(2);
    do_reset();
    n_chk++;
    if (bus.rdout !== '0 || bus.fill_cnt !== '0) begin
      n_fail++;
      $display("FAIL post_reset got=%h/%0d exp=0/0", bus.rdout, bus.fill_cnt);
    end
    idle(2);

    // Reset while a read is in flight discards it.
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1, 0, 1'b0);
    do_reset();
    idle(4);

    // Overfill past N: saturation and wrap-around reads.
    for (int i = 0; i < N + 6; i++) step(1'b1, i + 1, 1'b0, 0, 1'b0);
    step_dir(1'b0, 0, 0, desc(N + 6), '1);
    step_dir(1'b0, 0, (1 << AW) - 1, desc(14), '1);
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit we, re, rst;
      int a, x;
      we  = ($urandom_range(0, 1) == 1);
      re  = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 499) == 0);
      x   = int'($urandom_range(0, (1 << DW) - 1));
      if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 3));
      else a = int'($urandom_range(0, (1 << AW) - 1));
      step(we, x, re, a, rst);
    end
    idle(4);

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
